// File: rtl/io_flash_ctrl.sv
// io_flash_ctrl: parallel I/O sequencer and boot-time flash loader for the HMMM core.
// Serves read/write instructions (stalling the core on read) and streams words from
// parallelIn into instruction ROM while holding the core.
// Optional build macro: IO_SYNC_EN -- adds a two-flop synchronizer on inputReady.
module io_flash_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flashEnable,
    input  logic                  inputReady,
    output logic                  inputWaiting,
    input  logic [DATA_WIDTH-1:0] parallelIn,
    output logic [DATA_WIDTH-1:0] parallelOut,
    output logic                  outValid,
    input  logic                  ioRead,
    input  logic                  ioWrite,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdValid,
    output logic                  IObusy,
    output logic                  romWE,
    output logic [ADDR_WIDTH-1:0] romWA,
    output logic [DATA_WIDTH-1:0] romWD,
    output logic                  coreHold,
    output logic                  flashDone
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        FLASH_WAIT,
        FLASH_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready_s;
    logic                  ready_prev;
    logic                  ready_edge;

`ifdef IO_SYNC_EN
    logic [1:0] ready_sync;

    // Two-flop synchronizer; resets high so a stuck-high line is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) ready_sync <= 2'b11;
        else       ready_sync <= {ready_sync[0], inputReady};
    end
    assign ready_s = ready_sync[1];
`else
    assign ready_s = inputReady;
`endif

    // Previous strobe level; resets high so only a genuine low-to-high transition captures.
    always_ff @(posedge clk) begin
        if (reset) ready_prev <= 1'b1;
        else       ready_prev <= ready_s;
    end

    assign ready_edge = ready_s & ~ready_prev;

    // Status decoded from registered state only.
    assign inputWaiting = (state == RD_WAIT) || (state == FLASH_WAIT);
    assign coreHold     = (state == FLASH_WAIT) || (state == FLASH_DONE);
    assign flashDone    = (state == FLASH_DONE);

    // Stall is combinational so the core freezes in the very first cycle of a read.
    assign IObusy = ~reset &
                    (((state == IDLE) & ioRead & ~flashEnable) | (state == RD_WAIT));

    // Main sequencer: state, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            parallelOut <= '0;
            outValid    <= 1'b0;
            rdData      <= '0;
            rdValid     <= 1'b0;
            romWE       <= 1'b0;
            romWA       <= '0;
            romWD       <= '0;
        end else begin
            outValid <= 1'b0;
            rdValid  <= 1'b0;
            romWE    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flashEnable) begin
                        state <= FLASH_WAIT;
                        cnt   <= '0;
                    end else if (ioRead) begin
                        // A simultaneous write is an illegal combination and is dropped.
                        state <= RD_WAIT;
                    end else if (ioWrite) begin
                        parallelOut <= wrData;
                        outValid    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (flashEnable) begin
                        // Flash request aborts the pending read; no rdValid for it.
                        state <= FLASH_WAIT;
                        cnt   <= '0;
                    end else if (ready_edge) begin
                        rdData  <= parallelIn;
                        rdValid <= 1'b1;
                        state   <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                FLASH_WAIT: begin
                    if (ready_edge) begin
                        // A word arriving with the fall of flashEnable is still written.
                        romWE <= 1'b1;
                        romWA <= cnt;
                        romWD <= parallelIn;
                        cnt   <= cnt + 1'b1;
                        if (cnt == '1 || !flashEnable) state <= FLASH_DONE;
                    end else if (!flashEnable) begin
                        state <= FLASH_DONE;
                    end
                end
                FLASH_DONE: begin
                    // Hold here until the request drops so a wrap cannot re-flash.
                    if (!flashEnable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_flash_ctrl.sv
// Directed testbench for io_flash_ctrl (default build, IO_SYNC_EN undefined).
module tb_io_flash_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flashEnable;
    logic        inputReady;
    logic        inputWaiting;
    logic [15:0] parallelIn;
    logic [15:0] parallelOut;
    logic        outValid;
    logic        ioRead;
    logic        ioWrite;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        rdValid;
    logic        IObusy;
    logic        romWE;
    logic [7:0]  romWA;
    logic [15:0] romWD;
    logic        coreHold;
    logic        flashDone;

    int tests  = 0;
    int errors = 0;

    io_flash_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flashEnable(flashEnable), .inputReady(inputReady),
        .inputWaiting(inputWaiting), .parallelIn(parallelIn), .parallelOut(parallelOut),
        .outValid(outValid), .ioRead(ioRead), .ioWrite(ioWrite), .wrData(wrData),
        .rdData(rdData), .rdValid(rdValid), .IObusy(IObusy), .romWE(romWE),
        .romWA(romWA), .romWD(romWD), .coreHold(coreHold), .flashDone(flashDone)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe: high for a cycle (captured at that edge), then low for a cycle.
    task automatic pulse_hi(input logic [15:0] word);
        parallelIn = word;
        inputReady = 1'b1;
        tick();
    endtask

    task automatic pulse_lo();
        inputReady = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; flashEnable = 1'b0; inputReady = 1'b1; parallelIn = 16'hFFFF;
        ioRead = 1'b0; ioWrite = 1'b0; wrData = '0;

        // Reset, with inputReady stuck high
        tick(); tick();
        ioRead = 1'b1; #1;
        chk("busy_in_reset", IObusy, 0);
        ioRead = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("rst_busy", IObusy, 0);
        chk("rst_waiting", inputWaiting, 0);
        chk("rst_hold", coreHold, 0);
        chk("rst_romWE", romWE, 0);
        chk("rst_rdData", rdData, 0);
        chk("rst_pout", parallelOut, 0);
        chk("rst_outValid", outValid, 0);
        chk("rst_flashDone", flashDone, 0);
        inputReady = 1'b0;
        tick();

        // Write
        ioWrite = 1'b1; wrData = 16'h00A5; #1;
        chk("wr_busy", IObusy, 0);
        tick();
        ioWrite = 1'b0;
        chk("wr_pout", parallelOut, 16'h00A5);
        chk("wr_outValid", outValid, 1);
        tick();
        chk("wr_outValid_drop", outValid, 0);
        chk("wr_pout_hold", parallelOut, 16'h00A5);

        // Read with 5 cycles of wait
        ioRead = 1'b1; #1;
        chk("rd_busy_first", IObusy, 1);
        tick();
        chk("rd_waiting", inputWaiting, 1);
        repeat (4) tick();
        chk("rd_busy_wait", IObusy, 1);
        chk("rd_novalid", rdValid, 0);
        pulse_hi(16'h1234);
        chk("rd_valid", rdValid, 1);
        chk("rd_data", rdData, 16'h1234);
        chk("rd_busy_done", IObusy, 0);
        chk("rd_wait_done", inputWaiting, 0);
        inputReady = 1'b0;
        tick();
        chk("rd_valid_drop", rdValid, 0);
        chk("rd2_busy", IObusy, 1);
        tick();
        chk("rd2_waiting", inputWaiting, 1);
        pulse_hi(16'hBEEF);
        chk("rd2_valid", rdValid, 1);
        chk("rd2_data", rdData, 16'hBEEF);
        ioRead = 1'b0;
        pulse_lo();
        chk("rd2_idle_busy", IObusy, 0);
        chk("rd2_idle_wait", inputWaiting, 0);

        // Three-word flash then release
        flashEnable = 1'b1;
        tick();
        chk("fl_hold", coreHold, 1);
        chk("fl_waiting", inputWaiting, 1);
        chk("fl_busy", IObusy, 0);
        pulse_hi(16'h6001);
        chk("fl0_we", romWE, 1); chk("fl0_wa", romWA, 0); chk("fl0_wd", romWD, 16'h6001);
        pulse_lo();
        chk("fl0_we_drop", romWE, 0);
        pulse_hi(16'h6102);
        chk("fl1_we", romWE, 1); chk("fl1_wa", romWA, 1); chk("fl1_wd", romWD, 16'h6102);
        pulse_lo();
        pulse_hi(16'h0000);
        chk("fl2_we", romWE, 1); chk("fl2_wa", romWA, 2); chk("fl2_wd", romWD, 16'h0000);
        pulse_lo();
        flashEnable = 1'b0;
        tick();
        chk("fl_done", flashDone, 1);
        chk("fl_done_hold", coreHold, 1);
        chk("fl_done_wait", inputWaiting, 0);
        tick();
        chk("fl_done_drop", flashDone, 0);
        chk("fl_hold_drop", coreHold, 0);

        // Edge coincides with the fall of flashEnable: word still written
        flashEnable = 1'b1;
        tick();
        parallelIn = 16'hAAAA; inputReady = 1'b1; flashEnable = 1'b0;
        tick();
        chk("same_we", romWE, 1); chk("same_wa", romWA, 0); chk("same_wd", romWD, 16'hAAAA);
        chk("same_done", flashDone, 1);
        pulse_lo();
        chk("same_idle", coreHold, 0);

        // Full 256-word flash with flashEnable held
        flashEnable = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            pulse_hi(16'h5A00 ^ 16'(i));
            chk("full_we", romWE, 1);
            chk("full_wa", romWA, 32'(i));
            chk("full_wd", romWD, 32'(16'h5A00 ^ 16'(i)));
            pulse_lo();
        end
        chk("wrap_done", flashDone, 1);
        chk("wrap_hold", coreHold, 1);
        chk("wrap_wait", inputWaiting, 0);
        pulse_hi(16'hDEAD);
        chk("wrap_257_we", romWE, 0);
        pulse_lo();
        chk("wrap_257_we2", romWE, 0);
        chk("wrap_257_wa", romWA, 255);
        repeat (3) tick();
        chk("wrap_stay", flashDone, 1);
        flashEnable = 1'b0;
        tick();
        chk("wrap_exit_done", flashDone, 0);
        chk("wrap_exit_hold", coreHold, 0);

        // Read aborted by flash request
        ioRead = 1'b1;
        tick();
        chk("ab_waiting", inputWaiting, 1);
        flashEnable = 1'b1;
        tick();
        ioRead = 1'b0;
        chk("ab_still_wait", inputWaiting, 1);
        chk("ab_novalid", rdValid, 0);
        chk("ab_hold", coreHold, 1);
        chk("ab_busy", IObusy, 0);
        pulse_hi(16'h7777);
        chk("ab_we", romWE, 1); chk("ab_wa", romWA, 0); chk("ab_wd", romWD, 16'h7777);
        chk("ab_novalid2", rdValid, 0);
        pulse_lo();
        for (int i = 1; i < 7; i++) begin
            pulse_hi(16'(i));
            pulse_lo();
        end
        chk("mid_wa6", romWA, 6);

        // Reset mid-flash at cnt = 7
        reset = 1'b1;
        tick();
        chk("mr_hold", coreHold, 0);
        chk("mr_wait", inputWaiting, 0);
        chk("mr_we", romWE, 0);
        chk("mr_wa", romWA, 0);
        chk("mr_rdData", rdData, 0);
        chk("mr_pout", parallelOut, 0);
        reset = 1'b0;
        tick();
        chk("mr_reflash_hold", coreHold, 1);
        pulse_hi(16'h0BAD);
        chk("mr_cnt0_we", romWE, 1);
        chk("mr_cnt0_wa", romWA, 0);
        pulse_lo();
        flashEnable = 1'b0;
        tick(); tick();
        chk("mr_end_hold", coreHold, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
